// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment codes {a..g} and the capture FSM states.
// Also used by the binary-to-seven encoder, so the codes must stay in step with it.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } cap_state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational inverse of the seven-segment encoder: pattern -> nibble, err for anything
// that is not one of the sixteen legal codes (blank included).
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] nibble_o,
    output logic       err_o
);

    // Pattern lookup against the shared code table
    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b0;
        case (seg_n_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: begin
                nibble_o = 4'h0;
                err_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed active-low seven-segment bus, captures each digit once it has been
// steady long enough, and presents complete frames through a valid/ready register.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [6:0]            seg_n_i,
    input  logic [DIGITS-1:0]     an_n_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     digit_err_o,
    output logic                  frame_valid_o,
    input  logic                  frame_ready_i,
    output logic                  overrun_o
);

    localparam int                SW       = DIGITS + 7;
    localparam int                CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] ONE_D    = {{(DIGITS-1){1'b0}}, 1'b1};

    function automatic logic is_one_hot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - ONE_D)) == '0);
    endfunction

    logic [SW-1:0]         sync_q [SYNC_STAGES];
    logic [SW-1:0]         prev_q;
    cap_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   slots_q, slots_d;
    logic [DIGITS-1:0]     slot_err_q, slot_err_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     err_q, err_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic [SW-1:0]         samp_s;
    logic [DIGITS-1:0]     an_low_s;
    logic                  one_hot_s;
    logic                  changed_s;
    logic                  capture_s;
    logic                  accept_s;
    logic                  complete_s;
    logic [3:0]            nib_s;
    logic                  nib_err_s;

    assign samp_s    = sync_q[SYNC_STAGES-1];
    assign an_low_s  = ~samp_s[SW-1:7];
    assign one_hot_s = is_one_hot(an_low_s);
    assign changed_s = (samp_s != prev_q);
    assign accept_s  = valid_q && frame_ready_i;

    seven_seg_decode u_decode (
        .seg_n_i  (samp_s[6:0]),
        .nibble_o (nib_s),
        .err_o    (nib_err_s)
    );

    // Synchroniser chain plus one-cycle-old sample; idle bus (all ones) after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            prev_q <= '1;
        end else begin
            sync_q[0] <= {an_n_i, seg_n_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= samp_s;
        end
    end

    // Settle FSM: a capture fires once per steady run of a single-select sample
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (one_hot_s) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (changed_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = one_hot_s ? S_SETTLE : S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    capture_s = 1'b1;
                    state_d   = S_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HELD: begin
                if (changed_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = one_hot_s ? S_SETTLE : S_IDLE;
                end else begin
                    state_d = S_HELD;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Working slots, completion, and the output frame handshake
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            slots_d[4*i +: 4] = (capture_s && an_low_s[i]) ? nib_s : slots_q[4*i +: 4];
            slot_err_d[i]     = (capture_s && an_low_s[i]) ? nib_err_s : slot_err_q[i];
        end
        mask_d     = mask_q | (capture_s ? an_low_s : '0);
        complete_s = capture_s && (mask_d == '1);
        value_d    = value_q;
        err_d      = err_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (complete_s) begin
            mask_d = '0;
            if (!valid_q || accept_s) begin
                value_d   = slots_d;
                err_d     = slot_err_d;
                valid_d   = 1'b1;
                overrun_d = accept_s ? 1'b0 : overrun_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept_s) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            slots_q    <= '0;
            slot_err_q <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slots_q    <= slots_d;
            slot_err_q <= slot_err_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign value_o       = value_q;
    assign digit_err_o   = err_q;
    assign frame_valid_o = valid_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench: a pin-level run-length model predicts captures and frames; a monitor
// compares every presented frame and the valid/overrun flags each cycle.
module tb_seven_seg_capture;

    localparam int DIGITS = 4;
    localparam int STABLE = 8;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic        frame_ready = 1'b1;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        overrun;

    always #5 clk = ~clk;

    seven_seg_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .seg_n_i       (seg_n),
        .an_n_i        (an_n),
        .value_o       (value),
        .digit_err_o   (digit_err),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .overrun_o     (overrun)
    );

    logic [6:0] codes [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {err, nibble} by table search
    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == s) return {1'b0, 4'(i)};
        end
        return 5'b1_0000;
    endfunction

    function automatic bit single_select(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) n++;
        end
        return n == 1;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int due; logic [3:0] an; logic [6:0] seg; } cap_t;
    typedef struct { logic [15:0] v; logic [3:0] e; } frm_t;

    cap_t        pend[$];
    frm_t        exp_q[$];
    logic [10:0] m_prev;
    int          m_run, m_cyc, m_d;
    logic [15:0] m_work_v;
    logic [3:0]  m_work_e, m_mask;
    bit          m_valid, m_ov, m_acc, m_done;
    cap_t        m_cap;
    logic [4:0]  m_dec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
            m_prev = 11'h7FF; m_run = 0; m_cyc = 0;
            m_work_v = '0; m_work_e = '0; m_mask = '0;
            m_valid = 0; m_ov = 0;
        end else begin
            m_cyc++;
            m_acc  = m_valid && frame_ready;
            m_done = 0;
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                m_cap = pend.pop_front();
                m_dec = ref_decode(m_cap.seg);
                m_d = 0;
                for (int i = 0; i < 4; i++) if (!m_cap.an[i]) m_d = i;
                m_work_v[4*m_d +: 4] = m_dec[3:0];
                m_work_e[m_d] = m_dec[4];
                m_mask[m_d] = 1'b1;
                if (m_mask == 4'hF) begin
                    m_done = 1;
                    m_mask = '0;
                end
            end
            if (m_done) begin
                if (!m_valid || m_acc) begin
                    exp_q.push_back('{m_work_v, m_work_e});
                    m_valid = 1;
                    if (m_acc) m_ov = 0;
                end else begin
                    m_ov = 1;
                end
            end else if (m_acc) begin
                m_valid = 0;
                m_ov = 0;
            end
            // A capture happens SYNC edges after the pins have been steady for STABLE samples
            if ({an_n, seg_n} == m_prev) m_run++;
            else m_run = 1;
            m_prev = {an_n, seg_n};
            if (m_run == STABLE && single_select(an_n))
                pend.push_back('{m_cyc + SYNC, an_n, seg_n});
        end
    end

    // ---------------- monitor ----------------
    int          frames_seen = 0;
    logic [15:0] last_v;
    logic [3:0]  last_e;
    bit          prev_valid = 0;
    frm_t        got;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            check({value, digit_err, frame_valid, overrun} == '0, "reset_outputs",
                  {value, digit_err, frame_valid, overrun}, 32'h0);
            prev_valid = 0;
        end else begin
            check(frame_valid == m_valid, "frame_valid", frame_valid, m_valid);
            check(overrun == m_ov, "overrun", overrun, m_ov);
            if (frame_valid && (!prev_valid || frame_ready)) begin
                frames_seen++;
                last_v = value;
                last_e = digit_err;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_frame", {digit_err, value}, 32'h0);
                end else begin
                    got = exp_q.pop_front();
                    check(value == got.v && digit_err == got.e, "frame",
                          {digit_err, value}, {got.e, got.v});
                end
            end
            prev_valid = frame_valid;
        end
    end

    // ---------------- stimulus ----------------
    bit rand_ready = 0;

    task automatic show(input int d, input logic [6:0] seg, input int cycles);
        an_n  = ~(4'b0001 << d);
        seg_n = seg;
        repeat (cycles) begin
            if (rand_ready) frame_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic idle(input int cycles);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        repeat (cycles) @(negedge clk);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: basic frame
        base = frames_seen;
        show(0, codes[3], 20); show(1, codes[10], 20); show(2, codes[0], 20); show(3, codes[15], 20);
        idle(4);
        check(frames_seen == base + 1, "t1_frame_count", frames_seen - base, 1);
        check(last_v == 16'hF0A3, "t1_value", last_v, 16'hF0A3);
        check(last_e == 4'h0, "t1_err", last_e, 4'h0);

        // 2: glitching digit 1 never captures until it holds
        base = frames_seen;
        show(0, codes[1], 20); show(2, codes[2], 20); show(3, codes[3], 20);
        for (int k = 0; k < 6; k++) show(1, codes[(k % 2 == 0) ? 5 : 6], 5);
        check(frames_seen == base, "t2_no_frame_while_glitching", frames_seen - base, 0);
        show(1, codes[7], 12);
        idle(4);
        check(frames_seen == base + 1, "t2_frame_count", frames_seen - base, 1);
        check(last_v == 16'h3271, "t2_value", last_v, 16'h3271);

        // 3: blank digit flagged
        show(0, codes[5], 20); show(1, codes[9], 20); show(2, 7'b1111111, 20); show(3, codes[12], 20);
        idle(4);
        check(last_e == 4'b0100, "t3_err", last_e, 4'b0100);
        check(last_v == 16'hC095, "t3_value", last_v, 16'hC095);

        // 4: consumer stalled across two frames
        frame_ready = 1'b0;
        show(0, codes[1], 20); show(1, codes[2], 20); show(2, codes[3], 20); show(3, codes[4], 20);
        show(0, codes[8], 20); show(1, codes[8], 20); show(2, codes[8], 20); show(3, codes[8], 20);
        idle(2);
        check(value == 16'h4321, "t4_held_value", value, 16'h4321);
        check(overrun == 1'b1, "t4_overrun_set", overrun, 1);
        frame_ready = 1'b1;
        @(negedge clk);
        check(frame_valid == 1'b0, "t4_valid_cleared", frame_valid, 0);
        check(overrun == 1'b0, "t4_overrun_cleared", overrun, 0);

        // 5: two selects low is ignored, partial mask survives
        show(0, codes[6], 20); show(1, codes[7], 20); show(2, codes[8], 20);
        base = frames_seen;
        an_n = 4'b0011; seg_n = codes[9];
        repeat (50) @(negedge clk);
        check(frames_seen == base, "t5_no_frame", frames_seen - base, 0);
        show(3, codes[14], 20);
        idle(4);
        check(last_v == 16'hE876, "t5_value", last_v, 16'hE876);

        // 6: reset mid-frame discards captured digits
        show(0, codes[13], 20); show(1, codes[13], 20); show(2, codes[13], 20);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        base = frames_seen;
        show(0, codes[1], 20); show(1, codes[0], 20); show(2, codes[1], 20); show(3, codes[0], 20);
        idle(4);
        check(frames_seen == base + 1, "t6_frame_count", frames_seen - base, 1);
        check(last_v == 16'h0101, "t6_value", last_v, 16'h0101);

        // Random traffic against the model
        rand_ready = 1;
        for (int n = 0; n < 250; n++) begin
            logic [6:0] s;
            int d;
            d = $urandom_range(0, 3);
            s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : codes[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) begin
                an_n  = 4'($urandom);
                seg_n = s;
                repeat ($urandom_range(3, 16)) begin
                    frame_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end else begin
                show(d, s, $urandom_range(3, 16));
            end
        end
        rand_ready = 0;
        frame_ready = 1'b1;
        idle(30);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
